// File: rtl/riscv_ahb_arb.sv
// Two-master AHB-Lite arbiter: instruction (I) and data (D) requesters share one slave port.
// Define RISCV_AHB_ARB_RR_EN for round-robin arbitration; default is fixed D-over-I priority.
//
// state | meaning
// NONE  | no requester owns the address phase (IDLE driven)
// IOWN  | instruction requester owns the address phase
// DOWN  | data requester owns the address phase
module riscv_ahb_arb #(
  parameter int XLEN = 32
) (
  input  logic            hclk,
  input  logic            hreset,
  input  logic            i_busreq,
  input  logic            d_busreq,
  output logic            i_grant,
  output logic            d_grant,
  input  logic [XLEN-1:0] i_addr,
  input  logic [XLEN-1:0] d_addr,
  input  logic [1:0]      i_trans,
  input  logic [1:0]      d_trans,
  input  logic [2:0]      i_size,
  input  logic [2:0]      d_size,
  input  logic            i_write,
  input  logic            d_write,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [XLEN-1:0] d_wdata,
  output logic            i_ready,
  output logic            d_ready,
  output logic [XLEN-1:0] i_rdata,
  output logic [XLEN-1:0] d_rdata,
  output logic [1:0]      i_resp,
  output logic [1:0]      d_resp,
  output logic [XLEN-1:0] m_addr,
  output logic [1:0]      m_trans,
  output logic [2:0]      m_size,
  output logic            m_write,
  output logic [XLEN-1:0] m_wdata,
  input  logic            m_ready,
  input  logic [XLEN-1:0] m_rdata,
  input  logic [1:0]      m_resp,
  output logic [1:0]      m_owner
);

  typedef enum logic [1:0] {
    NONE = 2'b00,
    IOWN = 2'b01,
    DOWN = 2'b10
  } state_t;

  localparam logic [1:0] TR_IDLE  = 2'b00;
  localparam logic [1:0] RESP_ERR = 2'b01;
  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_I    = 2'b01;
  localparam logic [1:0] OWN_D    = 2'b10;

  state_t     state_q, state_d;
  logic [1:0] data_own_q;
  logic       own_req;
  logic [1:0] own_trans;
  logic       arb_en;
  logic       pick_d;

  always_comb begin
    own_req   = 1'b0;
    own_trans = TR_IDLE;
    case (state_q)
      IOWN: begin
        own_req   = i_busreq;
        own_trans = i_trans;
      end
      DOWN: begin
        own_req   = d_busreq;
        own_trans = d_trans;
      end
      default: ;
    endcase
  end

  // The second ERROR cycle has m_ready=1; the owner must still keep the bus then.
  assign arb_en = m_ready && (m_resp != RESP_ERR) &&
                  ((state_q == NONE) || !own_req || (own_trans == TR_IDLE));

`ifdef RISCV_AHB_ARB_RR_EN
  logic last_d_q;

  assign pick_d = d_busreq && (!i_busreq || !last_d_q);

  always_ff @(posedge hclk) begin
    if (hreset)
      last_d_q <= 1'b0;
    else if (arb_en && (i_busreq || d_busreq))
      last_d_q <= pick_d;
  end
`else
  assign pick_d = d_busreq;
`endif

  always_comb begin
    state_d = state_q;
    if (arb_en) begin
      if (pick_d)
        state_d = DOWN;
      else if (i_busreq)
        state_d = IOWN;
      else
        state_d = NONE;
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q    <= NONE;
      data_own_q <= OWN_NONE;
    end else begin
      state_q <= state_d;
      if (m_ready)
        data_own_q <= m_trans[1] ? state_q : OWN_NONE;
    end
  end

  assign i_grant = (state_q == IOWN);
  assign d_grant = (state_q == DOWN);
  assign m_owner = state_q;

  always_comb begin
    m_addr  = '0;
    m_trans = TR_IDLE;
    m_size  = 3'd0;
    m_write = 1'b0;
    case (state_q)
      IOWN: begin
        m_addr  = i_addr;
        m_trans = i_trans;
        m_size  = i_size;
        m_write = i_write;
      end
      DOWN: begin
        m_addr  = d_addr;
        m_trans = d_trans;
        m_size  = d_size;
        m_write = d_write;
      end
      default: ;
    endcase
  end

  always_comb begin
    m_wdata = '0;
    if (data_own_q == OWN_I)
      m_wdata = i_wdata;
    else if (data_own_q == OWN_D)
      m_wdata = d_wdata;
  end

  assign i_ready = m_ready;
  assign d_ready = m_ready;
  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;
  assign i_resp  = (data_own_q == OWN_I) ? m_resp : 2'b00;
  assign d_resp  = (data_own_q == OWN_D) ? m_resp : 2'b00;

endmodule

// File: tb/tb_riscv_ahb_arb.sv
// Vector-table bench for riscv_ahb_arb; expectations are queued at drive time and checked at negedge.
module tb_riscv_ahb_arb;

  localparam logic [31:0] IW = 32'h1111_1111;
  localparam logic [31:0] DW = 32'hDEAD_BEEF;

  logic        hclk = 1'b0;
  logic        hreset;
  logic        i_busreq, d_busreq, i_grant, d_grant;
  logic [31:0] i_addr, d_addr, i_wdata, d_wdata, i_rdata, d_rdata;
  logic [1:0]  i_trans, d_trans, i_resp, d_resp;
  logic [2:0]  i_size, d_size;
  logic        i_write, d_write, i_ready, d_ready;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [1:0]  m_trans, m_resp, m_owner;
  logic [2:0]  m_size;
  logic        m_write, m_ready;

  riscv_ahb_arb #(.XLEN(32)) dut (
    .hclk(hclk), .hreset(hreset),
    .i_busreq(i_busreq), .d_busreq(d_busreq),
    .i_grant(i_grant), .d_grant(d_grant),
    .i_addr(i_addr), .d_addr(d_addr),
    .i_trans(i_trans), .d_trans(d_trans),
    .i_size(i_size), .d_size(d_size),
    .i_write(i_write), .d_write(d_write),
    .i_wdata(i_wdata), .d_wdata(d_wdata),
    .i_ready(i_ready), .d_ready(d_ready),
    .i_rdata(i_rdata), .d_rdata(d_rdata),
    .i_resp(i_resp), .d_resp(d_resp),
    .m_addr(m_addr), .m_trans(m_trans), .m_size(m_size), .m_write(m_write),
    .m_wdata(m_wdata), .m_ready(m_ready), .m_rdata(m_rdata), .m_resp(m_resp),
    .m_owner(m_owner)
  );

  always #5 hclk = ~hclk;

  typedef struct {
    bit          chk;
    bit          rst;
    bit          ireq;
    logic [1:0]  itr;
    logic [31:0] iaddr;
    bit          dreq;
    logic [1:0]  dtr;
    logic [31:0] daddr;
    bit          mrdy;
    logic [1:0]  mresp;
    logic [31:0] mrdata;
    logic [1:0]  own;
    logic [1:0]  mtr;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [1:0]  iresp;
    logic [1:0]  dresp;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t mk(bit chk, bit rst,
                              bit ireq, logic [1:0] itr, logic [31:0] iaddr,
                              bit dreq, logic [1:0] dtr, logic [31:0] daddr,
                              bit mrdy, logic [1:0] mresp,
                              logic [1:0] own, logic [1:0] mtr, logic [31:0] maddr,
                              logic [31:0] mwdata, logic [1:0] iresp, logic [1:0] dresp);
    vec_t v;
    v.chk = chk;   v.rst = rst;
    v.ireq = ireq; v.itr = itr; v.iaddr = iaddr;
    v.dreq = dreq; v.dtr = dtr; v.daddr = daddr;
    v.mrdy = mrdy; v.mresp = mresp; v.mrdata = 32'h0;
    v.own = own;   v.mtr = mtr; v.maddr = maddr; v.mwdata = mwdata;
    v.iresp = iresp; v.dresp = dresp;
    return v;
  endfunction

  task automatic cmp(string name, int idx, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec=%0d actual=0x%08h required=0x%08h", name, idx, act, exp);
    end
  endtask

  task automatic drive(vec_t v, int idx);
    hreset   = v.rst;
    i_busreq = v.ireq; i_trans = v.itr; i_addr = v.iaddr;
    d_busreq = v.dreq; d_trans = v.dtr; d_addr = v.daddr;
    m_ready  = v.mrdy; m_resp = v.mresp;
    v.mrdata = 32'hC0DE_0000 | idx;
    m_rdata  = v.mrdata;
    sb.push_back(v);
  endtask

  int chk_idx = 0;
  always @(negedge hclk) begin
    if (sb.size() > 0) begin
      vec_t e;
      logic [2:0] exp_size;
      e = sb.pop_front();
      exp_size = (e.own == 2'b01) ? 3'd2 : (e.own == 2'b10) ? 3'd1 : 3'd0;
      if (e.chk) begin
        cmp("i_grant", chk_idx, {31'b0, i_grant}, {31'b0, e.own == 2'b01});
        cmp("d_grant", chk_idx, {31'b0, d_grant}, {31'b0, e.own == 2'b10});
        cmp("m_owner", chk_idx, {30'b0, m_owner}, {30'b0, e.own});
        cmp("m_trans", chk_idx, {30'b0, m_trans}, {30'b0, e.mtr});
        cmp("m_addr",  chk_idx, m_addr, e.maddr);
        cmp("m_size",  chk_idx, {29'b0, m_size}, {29'b0, exp_size});
        cmp("m_write", chk_idx, {31'b0, m_write}, {31'b0, e.own == 2'b10});
        cmp("m_wdata", chk_idx, m_wdata, e.mwdata);
        cmp("i_resp",  chk_idx, {30'b0, i_resp}, {30'b0, e.iresp});
        cmp("d_resp",  chk_idx, {30'b0, d_resp}, {30'b0, e.dresp});
        cmp("ready",   chk_idx, {30'b0, i_ready, d_ready}, {30'b0, e.mrdy, e.mrdy});
        cmp("i_rdata", chk_idx, i_rdata, e.mrdata);
        cmp("d_rdata", chk_idx, d_rdata, e.mrdata);
      end
      chk_idx++;
    end
  end

  initial begin
    hreset = 1'b1; i_busreq = 1'b0; d_busreq = 1'b0;
    i_trans = 2'b00; d_trans = 2'b00; i_addr = '0; d_addr = '0;
    i_size = 3'd2; d_size = 3'd1; i_write = 1'b0; d_write = 1'b1;
    i_wdata = IW; d_wdata = DW; m_ready = 1'b1; m_resp = 2'b00; m_rdata = '0;

    //          chk rst ireq itr iaddr     dreq dtr daddr    rdy resp own mtr maddr    mwdata ir dr
    vecs.push_back(mk(0, 1, 0, 0, 0,        0, 0, 0,        1, 0, 0, 0, 0,        0,  0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0,        0, 0, 0,        1, 0, 0, 0, 0,        0,  0, 0));
    // single I request, latency 1
    vecs.push_back(mk(1, 0, 1, 2, 'h100,    0, 0, 0,        1, 0, 0, 0, 0,        0,  0, 0));
    vecs.push_back(mk(1, 0, 1, 2, 'h100,    0, 0, 0,        1, 0, 1, 2, 'h100,    0,  0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 'h104,    0, 0, 0,        1, 0, 1, 0, 'h104,    IW, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 'h104,    0, 0, 0,        1, 0, 1, 0, 'h104,    0,  0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0,        0, 0, 0,        1, 0, 0, 0, 0,        0,  0, 0));
    // simultaneous requests, then D write handed over to I
    vecs.push_back(mk(1, 0, 1, 2, 'h200,    1, 2, 'h300,    1, 0, 0, 0, 0,        0,  0, 0));
    vecs.push_back(mk(1, 0, 1, 2, 'h200,    1, 2, 'h300,    1, 0, 2, 2, 'h300,    0,  0, 0));
    vecs.push_back(mk(1, 0, 1, 2, 'h200,    0, 2, 'h304,    1, 0, 2, 2, 'h304,    DW, 0, 0));
    vecs.push_back(mk(1, 0, 1, 2, 'h200,    0, 0, 'h304,    1, 0, 1, 2, 'h200,    DW, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 'h200,    0, 0, 0,        1, 0, 1, 0, 'h200,    IW, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0,        0, 0, 0,        1, 0, 0, 0, 0,        0,  0, 0));
    // D owner with three wait states while I requests
    vecs.push_back(mk(1, 0, 0, 0, 0,        1, 2, 'h400,    1, 0, 0, 0, 0,        0,  0, 0));
    vecs.push_back(mk(1, 0, 1, 2, 'h500,    1, 2, 'h400,    1, 0, 2, 2, 'h400,    0,  0, 0));
    vecs.push_back(mk(1, 0, 1, 2, 'h500,    1, 0, 'h400,    0, 0, 2, 0, 'h400,    DW, 0, 0));
    vecs.push_back(mk(1, 0, 1, 2, 'h500,    1, 0, 'h400,    0, 0, 2, 0, 'h400,    DW, 0, 0));
    vecs.push_back(mk(1, 0, 1, 2, 'h500,    1, 0, 'h400,    0, 0, 2, 0, 'h400,    DW, 0, 0));
    vecs.push_back(mk(1, 0, 1, 2, 'h500,    0, 0, 'h400,    1, 0, 2, 0, 'h400,    DW, 0, 0));
    vecs.push_back(mk(1, 0, 1, 2, 'h500,    0, 0, 0,        1, 0, 1, 2, 'h500,    0,  0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 'h500,    0, 0, 0,        1, 0, 1, 0, 'h500,    IW, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0,        0, 0, 0,        1, 0, 0, 0, 0,        0,  0, 0));
    // two-cycle ERROR on a D data phase; D drops its request in the second cycle
    vecs.push_back(mk(1, 0, 1, 2, 'h700,    1, 2, 'h600,    1, 0, 0, 0, 0,        0,  0, 0));
    vecs.push_back(mk(1, 0, 1, 2, 'h700,    1, 2, 'h600,    1, 0, 2, 2, 'h600,    0,  0, 0));
    vecs.push_back(mk(1, 0, 1, 2, 'h700,    1, 2, 'h604,    0, 1, 2, 2, 'h604,    DW, 0, 1));
    vecs.push_back(mk(1, 0, 1, 2, 'h700,    0, 0, 'h604,    1, 1, 2, 0, 'h604,    DW, 0, 1));
    vecs.push_back(mk(1, 0, 1, 2, 'h700,    0, 0, 'h604,    1, 0, 2, 0, 'h604,    0,  0, 0));
    vecs.push_back(mk(1, 0, 1, 2, 'h700,    0, 0, 0,        1, 0, 1, 2, 'h700,    0,  0, 0));
    // reset in the middle of a D SEQ beat
    vecs.push_back(mk(1, 0, 0, 0, 'h700,    1, 2, 'h800,    1, 0, 1, 0, 'h700,    IW, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0,        1, 2, 'h800,    1, 0, 2, 2, 'h800,    0,  0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0,        1, 3, 'h804,    1, 1, 2, 3, 'h804,    DW, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0,        1, 3, 'h808,    0, 1, 0, 0, 0,        0,  0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0,        1, 2, 'h808,    1, 0, 0, 0, 0,        0,  0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0,        0, 0, 'h808,    1, 0, 2, 0, 'h808,    0,  0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0,        0, 0, 0,        1, 0, 0, 0, 0,        0,  0, 0));

    @(posedge hclk); #1;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i], i);
      @(posedge hclk); #1;
    end

    // D granted, then D goes idle while I also requests: mode decides the winner
    drive(mk(1, 0, 0, 0, 0,     1, 2, 'h900, 1, 0, 0, 0, 0,     0, 0, 0), 100);
    @(posedge hclk); #1;
    drive(mk(1, 0, 1, 2, 'hA00, 1, 0, 'h904, 1, 0, 2, 0, 'h904, 0, 0, 0), 101);
    @(posedge hclk); #1;
`ifdef RISCV_AHB_ARB_RR_EN
    drive(mk(1, 0, 1, 2, 'hA00, 1, 0, 'h904, 1, 0, 1, 2, 'hA00, 0, 0, 0), 102);
`else
    drive(mk(1, 0, 1, 2, 'hA00, 1, 0, 'h904, 1, 0, 2, 0, 'h904, 0, 0, 0), 102);
`endif
    @(posedge hclk); #1;
    drive(mk(0, 1, 0, 0, 0,     0, 0, 0,     1, 0, 0, 0, 0,     0, 0, 0), 103);
    @(posedge hclk); #1;
    @(posedge hclk); #1;

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d required=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
